instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit_pkg.sv | 13 +
 rtl/instr_fetch_unit_fetch_queue.sv | 79 +++++++
 rtl/instr_fetch_unit.sv | 82 ++++++++
 tb/tb_instr_fetch_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-path constants and types used by the instruction fetch front end
// and the processor datapath it feeds.
package instr_fetch_unit_pkg;

  localparam int unsigned IFU_ADDR_W   = 32;
  localparam int unsigned IFU_INSTR_W  = 32;
  localparam logic [31:0] IFU_PC_RESET = 32'h0000_0000;
  localparam logic [31:0] IFU_PC_INCR  = 32'd4;

  // Occupancy of the 2-entry fetch queue (0..2).
  typedef logic [1:0] q_count_t;

endpackage

// File: rtl/instr_fetch_unit_fetch_queue.sv
// Two-entry {pc, instr} FIFO between instruction memory and the consumer.
// Entry 0 is always the head; the head keeps its last contents when the queue drains.
module instr_fetch_unit_fetch_queue
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W  = IFU_ADDR_W,
  parameter int unsigned INSTR_W = IFU_INSTR_W
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic               flush_i,
  input  logic [ADDR_W-1:0]  push_pc_i,
  input  logic [INSTR_W-1:0] push_instr_i,
  output q_count_t           count_o,
  output logic [ADDR_W-1:0]  head_pc_o,
  output logic [INSTR_W-1:0] head_instr_o
);

  logic [ADDR_W-1:0]  pc0_q, pc0_d, pc1_q, pc1_d;
  logic [INSTR_W-1:0] instr0_q, instr0_d, instr1_q, instr1_d;
  q_count_t           count_q, count_d;

  always_comb begin
    pc0_d    = pc0_q;
    pc1_d    = pc1_q;
    instr0_d = instr0_q;
    instr1_d = instr1_q;
    count_d  = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      // Shift only when a second entry exists, so a drained head keeps its value.
      if (pop_i && (count_q == 2'd2)) begin
        pc0_d    = pc1_q;
        instr0_d = instr1_q;
      end
      if (push_i) begin
        if ((count_q - {1'b0, pop_i}) == 2'd0) begin
          pc0_d    = push_pc_i;
          instr0_d = push_instr_i;
        end else begin
          pc1_d    = push_pc_i;
          instr1_d = push_instr_i;
        end
      end
      count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc0_q    <= '0;
      pc1_q    <= '0;
      instr0_q <= '0;
      instr1_q <= '0;
      count_q  <= '0;
    end else begin
      pc0_q    <= pc0_d;
      pc1_q    <= pc1_d;
      instr0_q <= instr0_d;
      instr1_q <= instr1_d;
      count_q  <= count_d;
    end
  end

  // The issue credit upstream must make a push into a full, non-draining queue impossible.
  always_ff @(posedge Clk) begin
    if (!Rst && !flush_i) begin
      assert (!(push_i && !pop_i && (count_q == 2'd2)));
    end
  end

  assign count_o      = count_q;
  assign head_pc_o    = pc0_q;
  assign head_instr_o = instr0_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, drives a 1-cycle-latency instruction
// memory, and buffers responses in a 2-entry queue so the datapath can stall.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = IFU_ADDR_W,
  parameter int unsigned       INSTR_W  = IFU_INSTR_W,
  parameter logic [ADDR_W-1:0] PC_RESET = ADDR_W'(IFU_PC_RESET)
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               PC_Sel,
  input  logic [ADDR_W-1:0]  PC_Target,
  output logic               Imem_En,
  output logic [ADDR_W-1:0]  Imem_Addr,
  input  logic [INSTR_W-1:0] Imem_Instr,
  output logic               Instr_Valid,
  output logic [INSTR_W-1:0] Instr_Out,
  output logic [ADDR_W-1:0]  PC_Out,
  input  logic               Instr_Ready
);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d;
  q_count_t          count;
  logic              pop, issue, push;
  logic [2:0]        credit;

  assign Instr_Valid = !Rst && (count != '0);
  assign pop         = Instr_Valid && Instr_Ready;

  // Queue slots already spoken for, counting the response still on its way back.
  assign credit  = {1'b0, count} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue   = !Rst && !PC_Sel && (credit < 3'd2);
  assign Imem_En   = issue;
  assign Imem_Addr = Rst ? PC_RESET : fetch_pc_q;

  // A response arriving during a redirect belongs to the abandoned path.
  assign push = inflight_q && !PC_Sel;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = issue;
    if (PC_Sel) begin
      fetch_pc_d = PC_Target & ~ADDR_W'(3);
    end else if (issue) begin
      fetch_pc_d    = fetch_pc_q + ADDR_W'(IFU_PC_INCR);
      inflight_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      fetch_pc_q    <= PC_RESET;
      inflight_pc_q <= PC_RESET;
      inflight_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
    end
  end

  instr_fetch_unit_fetch_queue #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_fetch_queue (
    .Clk          (Clk),
    .Rst          (Rst),
    .push_i       (push),
    .pop_i        (pop),
    .flush_i      (PC_Sel),
    .push_pc_i    (inflight_pc_q),
    .push_instr_i (Imem_Instr),
    .count_o      (count),
    .head_pc_o    (PC_Out),
    .head_instr_o (Instr_Out)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed cycle checks plus a randomized run scored
// against an in-order expected-PC stream.
module tb_instr_fetch_unit;

  logic        Clk = 1'b0;
  logic        Rst, PC_Sel, Instr_Ready;
  logic [31:0] PC_Target;
  logic        Imem_En, Instr_Valid;
  logic [31:0] Imem_Addr, Imem_Instr, Instr_Out, PC_Out;

  logic        Rst2, PC_Sel2, Instr_Ready2;
  logic [31:0] PC_Target2;
  logic        Imem_En2, Instr_Valid2;
  logic [31:0] Imem_Addr2, Imem_Instr2, Instr_Out2, PC_Out2;

  int checks = 0;
  int errors = 0;
  int delivered = 0;

  always #5 Clk = ~Clk;

  instr_fetch_unit dut (
    .Clk(Clk), .Rst(Rst), .PC_Sel(PC_Sel), .PC_Target(PC_Target),
    .Imem_En(Imem_En), .Imem_Addr(Imem_Addr), .Imem_Instr(Imem_Instr),
    .Instr_Valid(Instr_Valid), .Instr_Out(Instr_Out), .PC_Out(PC_Out),
    .Instr_Ready(Instr_Ready)
  );

  instr_fetch_unit #(.PC_RESET(32'hFFFF_FFF8)) dut2 (
    .Clk(Clk), .Rst(Rst2), .PC_Sel(PC_Sel2), .PC_Target(PC_Target2),
    .Imem_En(Imem_En2), .Imem_Addr(Imem_Addr2), .Imem_Instr(Imem_Instr2),
    .Instr_Valid(Instr_Valid2), .Instr_Out(Instr_Out2), .PC_Out(PC_Out2),
    .Instr_Ready(Instr_Ready2)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  // Instruction memories: 1-cycle read latency, garbage when not enabled.
  always @(posedge Clk) begin
    Imem_Instr  <= Imem_En  ? mem_word(Imem_Addr)  : $urandom;
    Imem_Instr2 <= Imem_En2 ? mem_word(Imem_Addr2) : $urandom;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic smp();
    @(negedge Clk);
  endtask

  // Scoreboard: the program stream is PC_RESET, +4, ... restarted at the target on a
  // redirect and at PC_RESET on reset; deliveries must follow it exactly, in order.
  logic [31:0] exp_q[$];
  logic [31:0] next_pc = 32'h0;
  logic        hold_pending = 1'b0;
  logic [31:0] hold_pc, hold_instr;

  always @(negedge Clk) begin
    logic [31:0] e;
    if (Rst) begin
      chk("rst_valid_low", {31'd0, Instr_Valid}, 32'd0);
      chk("rst_en_low", {31'd0, Imem_En}, 32'd0);
      chk("rst_addr", Imem_Addr, 32'h0);
      exp_q.delete();
      next_pc = 32'h0;
      hold_pending = 1'b0;
    end else begin
      if (PC_Sel) chk("en_during_redirect", {31'd0, Imem_En}, 32'd0);
      if (hold_pending) begin
        chk("stall_hold_valid", {31'd0, Instr_Valid}, 32'd1);
        chk("stall_hold_pc", PC_Out, hold_pc);
        chk("stall_hold_instr", Instr_Out, hold_instr);
      end
      if (Instr_Valid && Instr_Ready) begin
        e = exp_q.pop_front();
        chk("sb_pc", PC_Out, e);
        chk("sb_instr", Instr_Out, mem_word(e));
        delivered++;
      end
      hold_pending = Instr_Valid && !Instr_Ready && !PC_Sel;
      hold_pc      = PC_Out;
      hold_instr   = Instr_Out;
      if (PC_Sel) begin
        exp_q.delete();
        next_pc = {PC_Target[31:2], 2'b00};
      end
    end
    while (exp_q.size() < 4) begin
      exp_q.push_back(next_pc);
      next_pc = next_pc + 32'd4;
    end
  end

  initial begin
    logic [31:0] exp2 [4];
    int n2;
    Rst = 1'b1; PC_Sel = 1'b0; PC_Target = '0; Instr_Ready = 1'b1;
    Rst2 = 1'b1; PC_Sel2 = 1'b0; PC_Target2 = '0; Instr_Ready2 = 1'b1;

    step; step;
    step; Rst = 1'b0; smp;                           // first cycle out of reset
    chk("c0_en", {31'd0, Imem_En}, 32'd1);
    chk("c0_addr", Imem_Addr, 32'h0);
    chk("c0_valid", {31'd0, Instr_Valid}, 32'd0);
    chk("reset_pc_out", PC_Out, 32'h0);
    chk("reset_instr_out", Instr_Out, 32'h0);
    step; smp;
    chk("c1_addr", Imem_Addr, 32'h4);
    chk("c1_valid", {31'd0, Instr_Valid}, 32'd0);
    step; Instr_Ready = 1'b0; smp;                   // first valid, consumer stalls
    chk("c2_valid", {31'd0, Instr_Valid}, 32'd1);
    chk("c2_pc", PC_Out, 32'h0);
    chk("c2_en_credit", {31'd0, Imem_En}, 32'd0);
    repeat (4) begin step; smp; end
    chk("stall_en_low", {31'd0, Imem_En}, 32'd0);
    chk("stall_pc", PC_Out, 32'h0);
    step; Instr_Ready = 1'b1; smp;
    chk("release_pc0", PC_Out, 32'h0);
    step; smp;
    chk("release_pc4", PC_Out, 32'h4);
    step; smp;
    chk("release_pc8", PC_Out, 32'h8);

    step; Instr_Ready = 1'b0; PC_Sel = 1'b1; PC_Target = 32'h0000_0103; smp;
    chk("redir_en_low", {31'd0, Imem_En}, 32'd0);
    step; PC_Sel = 1'b0; Instr_Ready = 1'b1; smp;
    chk("redir_flushed", {31'd0, Instr_Valid}, 32'd0);
    chk("redir_addr", Imem_Addr, 32'h100);
    chk("redir_en", {31'd0, Imem_En}, 32'd1);
    step; smp;
    chk("redir_not_yet", {31'd0, Instr_Valid}, 32'd0);
    step; smp;
    chk("redir_valid_3", {31'd0, Instr_Valid}, 32'd1);
    chk("redir_pc", PC_Out, 32'h100);
    step; smp;
    chk("thru_pc104", PC_Out, 32'h104);

    step; PC_Sel = 1'b1; PC_Target = 32'h0000_2000; smp;   // redirect with pop
    chk("popredir_pc", PC_Out, 32'h108);
    step; PC_Sel = 1'b0; smp;
    chk("popredir_empty", {31'd0, Instr_Valid}, 32'd0);
    chk("empty_hold_pc", PC_Out, 32'h108);
    step; smp;
    step; Instr_Ready = 1'b0; smp;
    chk("popredir_target", PC_Out, 32'h2000);
    step; smp;
    step; Rst = 1'b1; smp;                           // queue full here
    chk("midrst_valid", {31'd0, Instr_Valid}, 32'd0);
    step; Rst = 1'b0; Instr_Ready = 1'b1; smp;
    chk("midrst_after_valid", {31'd0, Instr_Valid}, 32'd0);
    chk("midrst_addr", Imem_Addr, 32'h0);
    step; smp;
    step; smp;
    chk("midrst_restart_pc", PC_Out, 32'h0);

    step; Rst = 1'b1; PC_Sel = 1'b1; PC_Target = 32'h500; smp;
    step; Rst = 1'b0; PC_Sel = 1'b0; smp;
    chk("rst_beats_sel_addr", Imem_Addr, 32'h0);
    chk("rst_beats_sel_en", {31'd0, Imem_En}, 32'd1);

    for (int i = 0; i < 3000; i++) begin
      step;
      Instr_Ready = ($urandom_range(0, 99) < 70);
      PC_Sel      = ($urandom_range(0, 99) < 4);
      PC_Target   = $urandom;
      Rst         = ($urandom_range(0, 199) == 0);
    end
    step; Rst = 1'b0; PC_Sel = 1'b0; Instr_Ready = 1'b1;
    repeat (4) step;
    chk("progress", {31'd0, delivered >= 500}, 32'd1);

    // Wrap-around of the PC from a high reset vector.
    exp2[0] = 32'hFFFF_FFF8; exp2[1] = 32'hFFFF_FFFC;
    exp2[2] = 32'h0000_0000; exp2[3] = 32'h0000_0004;
    n2 = 0;
    step; Rst2 = 1'b0;
    for (int c = 0; c < 20 && n2 < 4; c++) begin
      smp;
      if (Instr_Valid2 && Instr_Ready2) begin
        chk("wrap_pc", PC_Out2, exp2[n2]);
        chk("wrap_instr", Instr_Out2, mem_word(exp2[n2]));
        n2++;
      end
      step;
    end
    chk("wrap_count", n2, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
